// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing / pixel output path.
// Defaults describe 640x480@60 with a 25.175 MHz pixel strobe.
package vga_pkg;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    localparam int CW_DEF = 8;

    typedef struct packed {
        logic [CW_DEF-1:0] r;
        logic [CW_DEF-1:0] g;
        logic [CW_DEF-1:0] b;
    } rgb_t;

    // Colour-bar channel enables {r,g,b}: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic logic [2:0] bar_mask(input logic [2:0] bar);
        logic [2:0] m;
        case (bar)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a configurable reset value.
// DEPTH=0 degenerates to a wire so callers need no special case.
module vga_delay_line #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, en};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Shift one stage per enable; reset fills every stage with RST_VAL.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
                end else if (en) begin
                    r_pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator and pixel output stage.
// Optional build macro: VGA_TESTPAT_EN replaces rgb_in with an internal
// 8-bar colour pattern framed by a 1-pixel white border.
//
// Alignment: rgb_in arrives PIPE_DLY strobes after its coordinate, so the
// raw sync/blank is delayed PIPE_DLY strobes and then registered together
// with the colour, keeping all pin outputs in the same output register.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_640,
    parameter int   H_FP     = H_FP_640,
    parameter int   H_SYNC   = H_SYNC_640,
    parameter int   H_BP     = H_BP_640,
    parameter int   V_ACTIVE = V_ACTIVE_480,
    parameter int   V_FP     = V_FP_480,
    parameter int   V_SYNC   = V_SYNC_480,
    parameter int   V_BP     = V_BP_480,
    parameter logic HS_POL   = SYNC_ACT_LOW,
    parameter logic VS_POL   = SYNC_ACT_LOW,
    parameter int   PIPE_DLY = 2,
    parameter int   CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [3*CW-1:0] rgb_in,
    output logic [10:0]   x,
    output logic [9:0]    y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 ||
            V_BP < 1 || PIPE_DLY < 0 || PIPE_DLY > 8 ||
            H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_err
            $error("vga_timing_gen: zero porch/sync, PIPE_DLY outside 0..8, or totals exceed x/y width");
        end
    endgenerate

    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic          r_first;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_act;
    logic          w_hs_dly;
    logic          w_vs_dly;
    logic          w_act_dly;
    logic [3*CW-1:0] w_rgb_src;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic [3*CW-1:0] r_rgb;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    // Raster counters; r_first marks the very first strobe after reset so it
    // reports a frame/line start even though (x,y) did not wrap into (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_first <= 1'b1;
        end else if (pix_en) begin
            r_first <= 1'b0;
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    assign line_start  = pix_en & ~rst & (r_first | w_x_last);
    assign frame_start = pix_en & ~rst & (r_first | (w_x_last & w_y_last));

    assign w_hs_raw = (r_x >= HS_START && r_x < HS_END) ? HS_POL : ~HS_POL;
    assign w_vs_raw = (r_y >= VS_START && r_y < VS_END) ? VS_POL : ~VS_POL;
    assign w_act    = (r_x < X_ACT) && (r_y < Y_ACT);

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   ({w_hs_raw, w_vs_raw, w_act}),
        .q   ({w_hs_dly, w_vs_dly, w_act_dly})
    );

`ifdef VGA_TESTPAT_EN
    // Bars are H_ACTIVE/8 wide so all eight colours fit the visible line.
    localparam logic [10:0] BAR_W = 11'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

    logic            w_border;
    logic [2:0]      w_bar;
    logic [2:0]      w_mask;
    logic [3*CW-1:0] w_pat;
    logic            w_unused_rgb;

    assign w_unused_rgb = ^rgb_in;
    assign w_border = (r_x == '0) || (r_x == X_ACT - 11'd1) ||
                      (r_y == '0) || (r_y == Y_ACT - 10'd1);
    assign w_bar    = 3'(r_x / BAR_W);
    assign w_mask   = w_border ? 3'b111 : bar_mask(w_bar);
    assign w_pat    = {{CW{w_mask[2]}}, {CW{w_mask[1]}}, {CW{w_mask[0]}}};

    // Pattern is generated from the current coordinate, so it takes the same
    // delay a real renderer would have.
    vga_delay_line #(
        .WIDTH   (3*CW),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ('0)
    ) u_pat_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (w_pat),
        .q   (w_rgb_src)
    );
`else
    assign w_rgb_src = rgb_in;
`endif

    // Pin output register: sync, blank and colour all load on the same strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (pix_en) begin
            r_hs      <= w_hs_dly;
            r_vs      <= w_vs_dly;
            r_blank_n <= w_act_dly;
            r_rgb     <= w_act_dly ? w_rgb_src : '0;
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign active  = w_act;
    assign hsync   = r_hs;
    assign vsync   = r_vs;
    assign blank_n = r_blank_n;
    assign {red, green, blue} = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. DUT A uses 640x480 defaults with
// PIPE_DLY=2; DUT B uses a tiny raster, active-high hsync and PIPE_DLY=0 so
// full frames fit in a short run. Both share clk/rst/pix_en/rgb_in.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [23:0] rgb_in;

    logic [10:0] xa, xb;
    logic [9:0]  ya, yb;
    logic        acta, lsa, fsa, hsa, vsa, bna;
    logic        actb, lsb, fsb, hsb, vsb, bnb;
    logic [7:0]  ra, ga, ba, rb, gb, bb;

    always #5 clk = ~clk;

    vga_timing_gen #(.PIPE_DLY(2)) u_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in),
        .x(xa), .y(ya), .active(acta), .line_start(lsa), .frame_start(fsa),
        .hsync(hsa), .vsync(vsa), .blank_n(bna), .red(ra), .green(ga), .blue(ba)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(0), .CW(8)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in),
        .x(xb), .y(yb), .active(actb), .line_start(lsb), .frame_start(fsb),
        .hsync(hsb), .vsync(vsb), .blank_n(bnb), .red(rb), .green(gb), .blue(bb)
    );

    // ---------------- reference model (strobe-count arithmetic) -------------
    typedef struct {int ha, hf, hs, hb, va, vf, vs, vb, pd; bit hp, vp;} tcfg_t;

    int          n;         // strobes since reset
    logic [23:0] last_rgb;  // rgb_in applied on strobe n
    bit          s_ls_a, s_fs_a, s_ls_b, s_fs_b;
    int          pass_cnt = 0;
    int          total = 0;

`ifdef VGA_TESTPAT_EN
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    function automatic tcfg_t cfg(input bit b);
        tcfg_t k;
        if (b) k = '{16, 2, 3, 4, 6, 1, 2, 2, 0, 1'b1, 1'b0};
        else   k = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        return k;
    endfunction

    function automatic int htot(input bit b);
        tcfg_t k = cfg(b);
        return k.ha + k.hf + k.hs + k.hb;
    endfunction

    function automatic int vtot(input bit b);
        tcfg_t k = cfg(b);
        return k.va + k.vf + k.vs + k.vb;
    endfunction

    function automatic int m_x(input bit b, input int c); return c % htot(b); endfunction
    function automatic int m_y(input bit b, input int c); return (c / htot(b)) % vtot(b); endfunction

    function automatic bit m_ls(input bit b, input int c);
        return (c == 0) || (c % htot(b) == htot(b) - 1);
    endfunction

    function automatic bit m_fs(input bit b, input int c);
        int f = htot(b) * vtot(b);
        return (c == 0) || (c % f == f - 1);
    endfunction

    function automatic bit m_act(input bit b, input int c);
        tcfg_t k = cfg(b);
        return (m_x(b, c) < k.ha) && (m_y(b, c) < k.va);
    endfunction

    // Pin outputs after c strobes show the coordinate issued PIPE_DLY+1 strobes back.
    function automatic bit m_hs(input bit b, input int c);
        tcfg_t k = cfg(b);
        int p = c - 1 - k.pd;
        int px;
        if (p < 0) return !k.hp;
        px = m_x(b, p);
        return (px >= k.ha + k.hf && px < k.ha + k.hf + k.hs) ? k.hp : !k.hp;
    endfunction

    function automatic bit m_vs(input bit b, input int c);
        tcfg_t k = cfg(b);
        int p = c - 1 - k.pd;
        int py;
        if (p < 0) return !k.vp;
        py = m_y(b, p);
        return (py >= k.va + k.vf && py < k.va + k.vf + k.vs) ? k.vp : !k.vp;
    endfunction

    function automatic bit m_bn(input bit b, input int c);
        int p = c - 1 - cfg(b).pd;
        if (p < 0) return 1'b0;
        return m_act(b, p);
    endfunction

    function automatic logic [23:0] m_rgb(input bit b, input int c);
`ifdef VGA_TESTPAT_EN
        tcfg_t k = cfg(b);
        int p = c - 1 - k.pd;
        int px, py;
        if (!m_bn(b, c)) return 24'h0;
        px = m_x(b, p);
        py = m_y(b, p);
        if (px == 0 || px == k.ha - 1 || py == 0 || py == k.va - 1) return 24'hFFFFFF;
        return BARS[px / (k.ha / 8)];
`else
        return m_bn(b, c) ? last_rgb : 24'h0;
`endif
    endfunction

    // ---------------- stimulus ----------------------------------------------
    task automatic step(input bit en, input logic [23:0] rgb);
        @(negedge clk);
        pix_en = en;
        rgb_in = rgb;
        #1;
        s_ls_a = lsa; s_fs_a = fsa; s_ls_b = lsb; s_fs_b = fsb;
        @(posedge clk);
        #1;
        if (en) begin
            n++;
            last_rgb = rgb;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        last_rgb = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b0; rgb_in = '0;
        repeat (3) @(negedge clk);
        total++; if (xa !== 11'd0) $display("FAIL reset_xa got %0d exp 0", xa); else pass_cnt++;
        total++; if (ya !== 10'd0) $display("FAIL reset_ya got %0d exp 0", ya); else pass_cnt++;
        total++; if (hsa !== 1'b1) $display("FAIL reset_hsa got %b exp 1", hsa); else pass_cnt++;
        total++; if (vsa !== 1'b1) $display("FAIL reset_vsa got %b exp 1", vsa); else pass_cnt++;
        total++; if (bna !== 1'b0) $display("FAIL reset_bna got %b exp 0", bna); else pass_cnt++;
        total++; if ({ra, ga, ba} !== 24'h0) $display("FAIL reset_rgba got %h exp 0", {ra, ga, ba}); else pass_cnt++;
        total++; if (lsa !== 1'b0 || fsa !== 1'b0) $display("FAIL reset_pulses got %b%b exp 00", lsa, fsa); else pass_cnt++;
        total++; if (hsb !== 1'b0) $display("FAIL reset_hsb got %b exp 0", hsb); else pass_cnt++;
        total++; if (xb !== 11'd0 || yb !== 10'd0) $display("FAIL reset_xyb got %0d,%0d exp 0,0", xb, yb); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        last_rgb = '0;
    endtask

    task automatic test_line();
        int np, pulses;
        logic [23:0] rgb;
        pulses = 0;
        for (int i = 0; i < 800; i++) begin
            np = n;
            rgb = 24'($urandom);
            step(1'b1, rgb);
            if (s_ls_a) pulses++;
            total++; if (s_ls_a !== m_ls(0, np)) $display("FAIL line_ls_a n=%0d got %b exp %b", np, s_ls_a, m_ls(0, np)); else pass_cnt++;
            total++; if (hsa !== m_hs(0, n)) $display("FAIL line_hs_a n=%0d got %b exp %b", n, hsa, m_hs(0, n)); else pass_cnt++;
        end
        total++; if (pulses !== 2) $display("FAIL line_pulses got %0d exp 2", pulses); else pass_cnt++;
        total++; if (xa !== 11'd0 || ya !== 10'd1) $display("FAIL line_end_xy got %0d,%0d exp 0,1", xa, ya); else pass_cnt++;
    endtask

    task automatic test_frame();
        int np, got_fs, exp_fs;
        logic [23:0] rgb;
        got_fs = 0; exp_fs = 0;
        for (int i = 0; i < 2 * 275 + 10; i++) begin
            np = n;
            rgb = 24'($urandom);
            step(1'b1, rgb);
            if (s_fs_b) got_fs++;
            if (m_fs(1, np)) exp_fs++;
            total++; if (s_ls_b !== m_ls(1, np)) $display("FAIL frame_ls_b n=%0d got %b exp %b", np, s_ls_b, m_ls(1, np)); else pass_cnt++;
            total++; if (s_fs_b !== m_fs(1, np)) $display("FAIL frame_fs_b n=%0d got %b exp %b", np, s_fs_b, m_fs(1, np)); else pass_cnt++;
            total++; if (xb !== 11'(m_x(1, n)) || yb !== 10'(m_y(1, n))) $display("FAIL frame_xy_b n=%0d got %0d,%0d exp %0d,%0d", n, xb, yb, m_x(1, n), m_y(1, n)); else pass_cnt++;
            total++; if (actb !== m_act(1, n)) $display("FAIL frame_act_b n=%0d got %b exp %b", n, actb, m_act(1, n)); else pass_cnt++;
            total++; if (hsb !== m_hs(1, n) || vsb !== m_vs(1, n)) $display("FAIL frame_sync_b n=%0d got %b%b exp %b%b", n, hsb, vsb, m_hs(1, n), m_vs(1, n)); else pass_cnt++;
            total++; if (bnb !== m_bn(1, n)) $display("FAIL frame_bn_b n=%0d got %b exp %b", n, bnb, m_bn(1, n)); else pass_cnt++;
            total++; if ({rb, gb, bb} !== m_rgb(1, n)) $display("FAIL frame_rgb_b n=%0d got %h exp %h", n, {rb, gb, bb}, m_rgb(1, n)); else pass_cnt++;
        end
        total++; if (got_fs !== exp_fs) $display("FAIL frame_fs_count got %0d exp %0d", got_fs, exp_fs); else pass_cnt++;
    endtask

    task automatic test_pixel();
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            step(1'b1, 24'hFF00FF);
            total++; if (bna !== m_bn(0, n)) $display("FAIL pixel_bn_a n=%0d got %b exp %b", n, bna, m_bn(0, n)); else pass_cnt++;
            total++; if ({ra, ga, ba} !== m_rgb(0, n)) $display("FAIL pixel_rgb_a n=%0d got %h exp %h", n, {ra, ga, ba}, m_rgb(0, n)); else pass_cnt++;
            if (n == 2) begin
                total++; if (bna !== 1'b0) $display("FAIL pixel_early_bn got %b exp 0", bna); else pass_cnt++;
            end
            if (n == 3) begin
                total++; if (bna !== 1'b1 || ra !== 8'hFF) $display("FAIL pixel_rise got %b/%h exp 1/ff", bna, ra); else pass_cnt++;
            end
            if (n == 643) begin
                total++; if (bna !== 1'b0 || ra !== 8'h00) $display("FAIL pixel_fall got %b/%h exp 0/00", bna, ra); else pass_cnt++;
            end
        end
    endtask

    task automatic test_gaps();
        int np;
        bit en;
        logic [23:0] rgb;
        for (int i = 0; i < 2000; i++) begin
            np = n;
            en = (i % 4 == 0);
            rgb = 24'($urandom);
            step(en, rgb);
            total++; if (s_ls_a !== (en && m_ls(0, np))) $display("FAIL gaps_ls_a i=%0d got %b exp %b", i, s_ls_a, en && m_ls(0, np)); else pass_cnt++;
            total++; if (s_fs_a !== (en && m_fs(0, np))) $display("FAIL gaps_fs_a i=%0d got %b exp %b", i, s_fs_a, en && m_fs(0, np)); else pass_cnt++;
            total++; if (s_fs_b !== (en && m_fs(1, np))) $display("FAIL gaps_fs_b i=%0d got %b exp %b", i, s_fs_b, en && m_fs(1, np)); else pass_cnt++;
            total++; if (xa !== 11'(m_x(0, n)) || ya !== 10'(m_y(0, n))) $display("FAIL gaps_xy_a i=%0d got %0d,%0d exp %0d,%0d", i, xa, ya, m_x(0, n), m_y(0, n)); else pass_cnt++;
            total++; if (xb !== 11'(m_x(1, n)) || yb !== 10'(m_y(1, n))) $display("FAIL gaps_xy_b i=%0d got %0d,%0d exp %0d,%0d", i, xb, yb, m_x(1, n), m_y(1, n)); else pass_cnt++;
            total++; if (acta !== m_act(0, n)) $display("FAIL gaps_act_a i=%0d got %b exp %b", i, acta, m_act(0, n)); else pass_cnt++;
            total++; if (hsa !== m_hs(0, n) || vsa !== m_vs(0, n)) $display("FAIL gaps_sync_a i=%0d got %b%b exp %b%b", i, hsa, vsa, m_hs(0, n), m_vs(0, n)); else pass_cnt++;
            total++; if (bna !== m_bn(0, n)) $display("FAIL gaps_bn_a i=%0d got %b exp %b", i, bna, m_bn(0, n)); else pass_cnt++;
            total++; if ({ra, ga, ba} !== m_rgb(0, n)) $display("FAIL gaps_rgb_a i=%0d got %h exp %h", i, {ra, ga, ba}, m_rgb(0, n)); else pass_cnt++;
            total++; if ({rb, gb, bb} !== m_rgb(1, n)) $display("FAIL gaps_rgb_b i=%0d got %h exp %h", i, {rb, gb, bb}, m_rgb(1, n)); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int tries, np;
        tries = 0;
        while (!(m_bn(1, n) && m_rgb(1, n) != 24'h0 && m_x(0, n) != 0) && tries < 100) begin
            step(1'b1, 24'($urandom) | 24'h1);
            tries++;
        end
        total++; if (tries >= 100) $display("FAIL areset_setup got %0d tries exp <100", tries); else pass_cnt++;
        pix_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (xa !== 11'd0 || xb !== 11'd0 || yb !== 10'd0) $display("FAIL areset_xy got %0d,%0d,%0d exp 0,0,0", xa, xb, yb); else pass_cnt++;
        total++; if (bnb !== 1'b0 || {rb, gb, bb} !== 24'h0) $display("FAIL areset_pix_b got %b/%h exp 0/0", bnb, {rb, gb, bb}); else pass_cnt++;
        total++; if (hsb !== 1'b0 || vsb !== 1'b1) $display("FAIL areset_sync_b got %b%b exp 01", hsb, vsb); else pass_cnt++;
        total++; if (lsa !== 1'b0 || fsb !== 1'b0) $display("FAIL areset_pulses got %b%b exp 00", lsa, fsb); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (xa !== 11'd0 || xb !== 11'd0) $display("FAIL areset_hold got %0d,%0d exp 0,0", xa, xb); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        pix_en = 1'b0;
        n = 0;
        last_rgb = '0;
        for (int i = 0; i < 40; i++) begin
            np = n;
            step(1'b1, 24'($urandom));
            total++; if (s_ls_b !== m_ls(1, np) || s_fs_b !== m_fs(1, np)) $display("FAIL areset_restart_pulse n=%0d got %b%b exp %b%b", np, s_ls_b, s_fs_b, m_ls(1, np), m_fs(1, np)); else pass_cnt++;
            total++; if (xb !== 11'(m_x(1, n)) || xa !== 11'(m_x(0, n))) $display("FAIL areset_restart_x n=%0d got %0d,%0d exp %0d,%0d", n, xb, xa, m_x(1, n), m_x(0, n)); else pass_cnt++;
            total++; if ({rb, gb, bb} !== m_rgb(1, n)) $display("FAIL areset_restart_rgb n=%0d got %h exp %h", n, {rb, gb, bb}, m_rgb(1, n)); else pass_cnt++;
        end
    endtask

`ifdef VGA_TESTPAT_EN
    task automatic test_testpat();
        do_reset();
        while (n < 40103) begin
            step(1'b1, 24'($urandom));
            if (n == 8003) begin
                total++; if ({ra, ga, ba} !== 24'hFFFFFF) $display("FAIL testpat_border got %h exp ffffff", {ra, ga, ba}); else pass_cnt++;
            end
        end
        total++; if ({ra, ga, ba} !== 24'hFFFF00) $display("FAIL testpat_bar1 got %h exp ffff00", {ra, ga, ba}); else pass_cnt++;
    endtask
`endif

    initial begin
        n = 0;
        last_rgb = '0;
        test_reset();
        test_line();
        test_frame();
        test_pixel();
        test_gaps();
        test_async_reset();
`ifdef VGA_TESTPAT_EN
        test_testpat();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
